// File: rtl/alu_display_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_display_sequencer_if
// Bundles the result handshake and the LED-mux feed of alu_display_sequencer.
//   ResultIn       [WIDTH] ALU function result
//   OverflowFlagIn [1]     ALU overflow flag for ResultIn
//   ResultValid    [1]     ResultIn/OverflowFlagIn valid this cycle
//   Ready          [1]     sequencer can accept a result
//   FuncOut        [WIDTH] registered result, feeds mux FuncIn
//   OverflowOut    [WIDTH] registered overflow pattern, feeds mux OverflowIn
//   Sel            [3]     mux select: 000 = function view, 001 = overflow view
//   Busy           [1]     display sequence in progress
//   Done           [1]     one-cycle pulse when a sequence completes
// Modports: master = result producer / mux side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface alu_display_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] ResultIn;
  logic             OverflowFlagIn;
  logic             ResultValid;
  logic             Ready;
  logic [WIDTH-1:0] FuncOut;
  logic [WIDTH-1:0] OverflowOut;
  logic [2:0]       Sel;
  logic             Busy;
  logic             Done;

  modport master (
    output ResultIn, OverflowFlagIn, ResultValid,
    input  Ready, FuncOut, OverflowOut, Sel, Busy, Done
  );

  modport slave (
    input  ResultIn, OverflowFlagIn, ResultValid,
    output Ready, FuncOut, OverflowOut, Sel, Busy, Done
  );
endinterface

// File: rtl/alu_display_sequencer.sv
// -----------------------------------------------------------------------------
// alu_display_sequencer
// Captures one ALU result plus overflow flag on a valid/ready handshake, then
// alternates the LED mux between the function view and the overflow view for
// ROUNDS pairs, each view held HOLD_CYCLES clocks, then pulses Done.
// Ports:
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset
//   bus    alu_display_sequencer_if.slave (handshake in, mux feed out)
// Parameters: WIDTH (data width), HOLD_CYCLES (>= 1), ROUNDS (>= 1).
// Optional feature macro: ALU_DISPLAY_RESTART_EN -- when defined, a new result
// during a display sequence restarts it (Ready stays high outside FINISH).
// All outputs are registered.
// -----------------------------------------------------------------------------
module alu_display_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int ROUNDS      = 3
) (
  input logic                   Clk,
  input logic                   Rst_n,
  alu_display_sequencer_if.slave bus
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_FUNC = 2'd1,
    SHOW_OVF  = 2'd2,
    FINISH    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    round_q, round_d;
  logic [WIDTH-1:0] func_q, func_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       sel_q, sel_d;

  logic capture;
  logic timer_last;

  assign capture    = bus.ResultValid && ready_q;
  assign timer_last = (timer_q == TIMER_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    round_d = round_q;
    func_d  = func_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          func_d  = bus.ResultIn;
          ovf_d   = {WIDTH{bus.OverflowFlagIn}};
          timer_d = '0;
          round_d = '0;
          state_d = SHOW_FUNC;
        end
      end
      SHOW_FUNC: begin
        if (timer_last) begin
          timer_d = '0;
          state_d = SHOW_OVF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SHOW_OVF: begin
        if (timer_last) begin
          timer_d = '0;
          if (round_q == ROUND_LAST) begin
            state_d = FINISH;
          end else begin
            round_d = round_q + RW'(1);
            state_d = SHOW_FUNC;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FINISH: begin
        timer_d = '0;
        round_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef ALU_DISPLAY_RESTART_EN
    // A fresh result aborts the running sequence; the aborted one never
    // reaches FINISH, so it produces no Done pulse.
    if (capture && (state_q == SHOW_FUNC || state_q == SHOW_OVF)) begin
      func_d  = bus.ResultIn;
      ovf_d   = {WIDTH{bus.OverflowFlagIn}};
      timer_d = '0;
      round_d = '0;
      state_d = SHOW_FUNC;
    end
`endif
  end

  // Status outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
`ifdef ALU_DISPLAY_RESTART_EN
    ready_d = (state_d != FINISH);
`else
    ready_d = (state_d == IDLE);
`endif
    busy_d  = (state_d == SHOW_FUNC) || (state_d == SHOW_OVF);
    done_d  = (state_d == FINISH);
    sel_d   = (state_d == SHOW_OVF) ? 3'b001 : 3'b000;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      round_q <= '0;
      func_q  <= '0;
      ovf_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      round_q <= round_d;
      func_q  <= func_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.Ready       = ready_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Sel         = sel_q;
  assign bus.FuncOut     = func_q;
  assign bus.OverflowOut = ovf_q;

endmodule

// File: tb/tb_alu_display_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_display_sequencer
// Two instances: A (HOLD_CYCLES=4, ROUNDS=2) and B (HOLD_CYCLES=1, ROUNDS=1).
// A reference model tracks each instance as "position within the sequence"
// and derives every output from that; outputs are compared every negedge.
// Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_display_sequencer;

`ifdef ALU_DISPLAY_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_display_sequencer_if #(.WIDTH(4)) if_a ();
  alu_display_sequencer_if #(.WIDTH(4)) if_b ();

  alu_display_sequencer #(.WIDTH(4), .HOLD_CYCLES(4), .ROUNDS(2)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .bus(if_a)
  );
  alu_display_sequencer #(.WIDTH(4), .HOLD_CYCLES(1), .ROUNDS(1)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .bus(if_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos 0 = idle; 1..2*H*R = busy cycle number; 2*H*R+1 = finish cycle.
  int         hold_c [2] = '{4, 1};
  int         round_c[2] = '{2, 1};
  int         m_pos  [2] = '{0, 0};
  logic [3:0] m_func [2] = '{4'h0, 4'h0};
  logic [3:0] m_ovf  [2] = '{4'h0, 4'h0};

  task automatic model_reset(input int idx);
    m_pos[idx]  = 0;
    m_func[idx] = 4'h0;
    m_ovf[idx]  = 4'h0;
  endtask

  task automatic model_step(input int idx, input logic v, input logic [3:0] r, input logic f);
    int total;
    total = 2 * hold_c[idx] * round_c[idx];
    if (v && (m_pos[idx] == 0 || (RESTART && m_pos[idx] <= total))) begin
      m_func[idx] = r;
      m_ovf[idx]  = f ? 4'hF : 4'h0;
      m_pos[idx]  = 1;
    end else if (m_pos[idx] > total) begin
      m_pos[idx] = 0;
    end else if (m_pos[idx] != 0) begin
      m_pos[idx] = m_pos[idx] + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset(0);
    else        model_step(0, if_a.ResultValid, if_a.ResultIn, if_a.OverflowFlagIn);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset(1);
    else        model_step(1, if_b.ResultValid, if_b.ResultIn, if_b.OverflowFlagIn);

  task automatic compare_inst(input int idx, input string tag,
                              input logic rdy, input logic bsy, input logic dn,
                              input logic [2:0] sel, input logic [3:0] fo,
                              input logic [3:0] oo);
    int total, pos;
    logic e_rdy, e_bsy, e_dn;
    logic [2:0] e_sel;
    total = 2 * hold_c[idx] * round_c[idx];
    pos   = m_pos[idx];
    e_rdy = 1'b0; e_bsy = 1'b0; e_dn = 1'b0; e_sel = 3'b000;
    if (pos == 0) begin
      e_rdy = 1'b1;
    end else if (pos <= total) begin
      e_rdy = RESTART;
      e_bsy = 1'b1;
      e_sel = (((pos - 1) / hold_c[idx]) % 2 == 1) ? 3'b001 : 3'b000;
    end else begin
      e_dn = 1'b1;
    end
    check({tag, ".ready"}, 32'(rdy), 32'(e_rdy));
    check({tag, ".busy"},  32'(bsy), 32'(e_bsy));
    check({tag, ".done"},  32'(dn),  32'(e_dn));
    check({tag, ".sel"},   32'(sel), 32'(e_sel));
    check({tag, ".func"},  32'(fo),  32'(m_func[idx]));
    check({tag, ".ovf"},   32'(oo),  32'(m_ovf[idx]));
  endtask

  always @(negedge clk) begin
    compare_inst(0, "A", if_a.Ready, if_a.Busy, if_a.Done, if_a.Sel, if_a.FuncOut, if_a.OverflowOut);
    compare_inst(1, "B", if_b.Ready, if_b.Busy, if_b.Done, if_b.Sel, if_b.FuncOut, if_b.OverflowOut);
  end

  // ---------------- directed stimulus ----------------
  task automatic drive_a(input logic v, input logic [3:0] r, input logic f);
    if_a.ResultValid = v; if_a.ResultIn = r; if_a.OverflowFlagIn = f;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, ".ready"}, 32'(if_a.Ready), 32'd1);
    check({tag, ".busy"},  32'(if_a.Busy),  32'd0);
    check({tag, ".done"},  32'(if_a.Done),  32'd0);
    check({tag, ".sel"},   32'(if_a.Sel),   32'd0);
    check({tag, ".func"},  32'(if_a.FuncOut),     32'd0);
    check({tag, ".ovf"},   32'(if_a.OverflowOut), 32'd0);
  endtask

  initial begin
    logic [15:0] sel_trace;
    int busy_cnt, done_cnt;

    rst_n = 1'b0;
    drive_a(1'b0, 4'h0, 1'b0);
    if_b.ResultValid = 1'b0; if_b.ResultIn = 4'h0; if_b.OverflowFlagIn = 1'b0;
    #12;
    check_reset_a("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Step 1: capture A/1; sel pattern, done, ready timing.
    drive_a(1'b1, 4'hA, 1'b1);
    @(negedge clk) drive_a(1'b0, 4'h0, 1'b0);
    check("cap1.func", 32'(if_a.FuncOut), 32'hA);
    check("cap1.ovf",  32'(if_a.OverflowOut), 32'hF);
    sel_trace = '0;
    for (int i = 0; i < 16; i++) begin
      sel_trace = {sel_trace[14:0], if_a.Sel[0]};
`ifndef ALU_DISPLAY_RESTART_EN
      if (i == 5) drive_a(1'b1, 4'h3, 1'b0);   // ignored while busy
      if (i == 6) drive_a(1'b0, 4'h0, 1'b0);
`endif
      @(negedge clk);
    end
    check("seq1.sel_trace", 32'(sel_trace), 32'h0F0F);
    check("seq1.done", 32'(if_a.Done), 32'd1);
    check("seq1.func_kept", 32'(if_a.FuncOut), 32'hA);
    @(negedge clk);
    check("seq1.ready_after", 32'(if_a.Ready), 32'd1);
    check("seq1.done_pulse", 32'(if_a.Done), 32'd0);

    // Step 2: capture 5 with overflow clear; model checks hold each cycle.
    drive_a(1'b1, 4'h5, 1'b0);
    @(negedge clk) drive_a(1'b0, 4'h0, 1'b0);
    check("cap2.func", 32'(if_a.FuncOut), 32'h5);
    check("cap2.ovf",  32'(if_a.OverflowOut), 32'h0);
    repeat (17) @(negedge clk);
    check("seq2.func_end", 32'(if_a.FuncOut), 32'h5);
    check("seq2.ready", 32'(if_a.Ready), 32'd1);

    // Step 3: async reset in the middle of SHOW_OVF.
    drive_a(1'b1, 4'hC, 1'b1);
    @(negedge clk) drive_a(1'b0, 4'h0, 1'b0);
    repeat (5) @(negedge clk);          // busy cycle 6: overflow view
    check("mid.sel_before", 32'(if_a.Sel), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_a("async_reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_reset.ready", 32'(if_a.Ready), 32'd1);
    check("post_reset.sel",   32'(if_a.Sel),   32'd0);

    // Step 4: instance B, HOLD_CYCLES=1, ROUNDS=1.
    if_b.ResultValid = 1'b1; if_b.ResultIn = 4'h9; if_b.OverflowFlagIn = 1'b1;
    @(negedge clk) if_b.ResultValid = 1'b0;
    check("B.c1.sel",  32'(if_b.Sel),  32'd0);
    check("B.c1.busy", 32'(if_b.Busy), 32'd1);
    @(negedge clk);
    check("B.c2.sel",  32'(if_b.Sel),  32'd1);
    @(negedge clk);
    check("B.c3.done",  32'(if_b.Done),  32'd1);
    check("B.c3.ready", 32'(if_b.Ready), 32'd0);
    @(negedge clk);
    check("B.c4.ready", 32'(if_b.Ready), 32'd1);

`ifdef ALU_DISPLAY_RESTART_EN
    // Step 5: restart at busy cycle 5 with 7.
    @(negedge clk);
    drive_a(1'b1, 4'hA, 1'b1);
    @(negedge clk) drive_a(1'b0, 4'h0, 1'b0);
    repeat (4) @(negedge clk);
    drive_a(1'b1, 4'h7, 1'b0);
    @(negedge clk) drive_a(1'b0, 4'h0, 1'b0);
    check("restart.func", 32'(if_a.FuncOut), 32'h7);
    check("restart.sel",  32'(if_a.Sel), 32'd0);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      busy_cnt += int'(if_a.Busy);
      done_cnt += int'(if_a.Done);
      @(negedge clk);
    end
    check("restart.busy_cycles", 32'(busy_cnt), 32'd16);
    check("restart.done_pulses", 32'(done_cnt), 32'd1);
`else
    busy_cnt = 0; done_cnt = 0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_display_sequencer.md
Name: alu_display_sequencer

Overview:
Upstream stage of the LED output mux. It captures one ALU result and its overflow flag on a valid/ready handshake and holds them stable. It then drives the mux select so the LEDs alternate between the function result and the overflow pattern for a fixed number of rounds. When finished it returns to idle and accepts the next result.

Parameters:
WIDTH, 4, width of the ALU result and of both data outputs to the mux
HOLD_CYCLES, 25000000, clock cycles each view is held (0.5 s at 50 MHz); must be >= 1
ROUNDS, 3, number of func/overflow display pairs per captured result; must be >= 1

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
ResultIn  input  WIDTH  ALU function result
OverflowFlagIn  input  1  ALU overflow flag for ResultIn
ResultValid  input  1  ResultIn/OverflowFlagIn valid this cycle
Ready  output  1  block can accept a result
FuncOut  output  WIDTH  registered result, feeds mux FuncIn
OverflowOut  output  WIDTH  registered overflow pattern, feeds mux OverflowIn
Sel  output  3  mux select: 3'b000 = function view, 3'b001 = overflow view
Busy  output  1  display sequence in progress
Done  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Interface: one clock Clk; reset Rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: state IDLE, Ready=1, Busy=0, Done=0, Sel=3'b000, FuncOut=0, OverflowOut=0. Hold timer = 0, round counter = 0.
- Timer width is $clog2(HOLD_CYCLES+1). Round counter width is $clog2(ROUNDS+1).
- Capture happens on a rising edge where ResultValid && Ready.
  - FuncOut <= ResultIn.
  - OverflowOut <= {WIDTH{OverflowFlagIn}}.
  - The state moves to SHOW_FUNC on that same edge, so latency from valid to new LED data is 1 cycle.
- ResultValid while Ready=0 is ignored; no capture and no state change.
- States:
  - IDLE: Ready=1, Busy=0, Sel=000. FuncOut/OverflowOut keep their last captured values. Go to SHOW_FUNC on capture.
  - SHOW_FUNC: Ready=0, Busy=1, Sel=000. Lasts exactly HOLD_CYCLES cycles (timer counts 0..HOLD_CYCLES-1), then go to SHOW_OVF with the timer cleared.
  - SHOW_OVF: Ready=0, Busy=1, Sel=001. Lasts exactly HOLD_CYCLES cycles.
    - On expiry with round == ROUNDS-1: go to FINISH.
    - On expiry otherwise: increment round, clear the timer, go to SHOW_FUNC.
  - FINISH: exactly one cycle. Done=1, Busy=0, Ready=0, Sel=000. Clear round and timer, then go to IDLE.
- Sequence length: 2*HOLD_CYCLES*ROUNDS busy cycles plus 1 FINISH cycle, then Ready rises.
- Sel only ever takes 3'b000 or 3'b001; codes 010..111 are never driven.
- With HOLD_CYCLES=1, each view lasts one cycle and Sel toggles every cycle.
- Reset mid-sequence: all state and outputs return to reset values immediately, and the captured data is lost.
- A result with OverflowFlagIn=0 still shows the overflow view, with all LEDs off.

Optional Feature:
Macro ALU_DISPLAY_RESTART_EN.
- Defined:
  - Ready is held at 1 in every state except FINISH.
  - ResultValid during SHOW_FUNC or SHOW_OVF recaptures the data, clears timer and round, and goes to SHOW_FUNC.
  - No Done pulse is produced for the aborted sequence.
  - ResultValid in FINISH is ignored.
- Not defined: behaviour exactly as above; no restart.

Test Plan:
- HOLD_CYCLES=4, ROUNDS=2. Reset, then ResultValid=1 with ResultIn=4'hA, OverflowFlagIn=1 for one cycle.
  - Next cycle: FuncOut=4'hA, OverflowOut=4'hF.
  - Sel is 000 x4, 001 x4, 000 x4, 001 x4.
  - Then Done=1 for one cycle, and Ready=1 on the following cycle.
- ResultIn=4'h5, OverflowFlagIn=0 -> OverflowOut=4'h0; FuncOut=4'h5 held through the whole sequence.
- Second ResultValid with 4'h3 asserted at busy cycle 6 (macro undefined) -> ignored; FuncOut stays 4'hA and Done arrives at the normal time.
- Rst_n pulled low asynchronously mid SHOW_OVF (between clock edges) -> outputs return to reset values immediately; after release, Ready=1 and Sel=000.
- HOLD_CYCLES=1, ROUNDS=1 -> Sel 000, 001, then Done; Ready returns 3 cycles after the capture edge.
- ALU_DISPLAY_RESTART_EN defined: new valid with 4'h7 at busy cycle 5 -> FuncOut=4'h7, sequence restarts (16 busy cycles from the restart), and only one Done pulse occurs.
